// File: rtl/instr_decode_stage.sv
// RV32/RV64 decode stage: field split, format classification, immediate generation
// and register-use qualifiers, behind a registered valid/ready skid buffer with flush.
module instr_decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_func3,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [6:0]      out_func7,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_rd_we,
   output logic            out_rs1_used,
   output logic            out_rs2_used,
   output logic            out_illegal
);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [XLEN-1:0] imm;
      fmt_e            fmt;
      logic            rd_we;
      logic            rs1_used;
      logic            rs2_used;
      logic            illegal;
   } entry_t;

   fmt_e        dec_fmt;
   logic [31:0] dec_imm32;
   entry_t      dec;

   entry_t m_q, m_d;
   entry_t k_q, k_d;
   logic   m_valid_q, m_valid_d;
   logic   k_valid_q, k_valid_d;

   logic accept;
   logic transfer;

   // NOTE: every signal driven in always_comb gets a default first, otherwise a
   // path that skips the assignment infers a latch.
   always_comb begin
      dec_fmt = FMT_ILL;
      case (in_instr[6:0])
         7'b0110011:                          dec_fmt = FMT_R;
         7'b0010011, 7'b0000011, 7'b1100111,
         7'b1110011, 7'b0001111:              dec_fmt = FMT_I;
         7'b0100011:                          dec_fmt = FMT_S;
         7'b1100011:                          dec_fmt = FMT_B;
         7'b0110111, 7'b0010111:              dec_fmt = FMT_U;
         7'b1101111:                          dec_fmt = FMT_J;
         7'b0111011: if (XLEN == 64)          dec_fmt = FMT_R;
         7'b0011011: if (XLEN == 64)          dec_fmt = FMT_I;
         default:                             dec_fmt = FMT_ILL;
      endcase
   end

   // Immediates are built at 32 bits and then sign-extended to XLEN in one place.
   always_comb begin
      dec_imm32 = '0;
      case (dec_fmt)
         FMT_I:   dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S:   dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B:   dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U:   dec_imm32 = {in_instr[31:12], 12'b0};
         FMT_J:   dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
         default: dec_imm32 = '0;
      endcase
   end

   always_comb begin
      dec.pc       = in_pc;
      dec.instr    = in_instr;
      dec.imm      = XLEN'($signed(dec_imm32));
      dec.fmt      = dec_fmt;
      dec.rd_we    = (dec_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (in_instr[11:7] != 5'd0);
      dec.rs1_used = dec_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
      dec.rs2_used = dec_fmt inside {FMT_R, FMT_S, FMT_B};
      dec.illegal  = (dec_fmt == FMT_ILL);
   end

   assign in_ready = ~k_valid_q;
   assign accept   = in_valid && in_ready;
   assign transfer = m_valid_q && out_ready;

   always_comb begin
      m_d       = m_q;
      k_d       = k_q;
      m_valid_d = m_valid_q;
      k_valid_d = k_valid_q;
      if (flush) begin
         m_valid_d = 1'b0;
         k_valid_d = 1'b0;
      end else if (!m_valid_q || transfer) begin
         // K can only be full while M is full, so it always refills M first.
         if (k_valid_q) begin
            m_d       = k_q;
            m_valid_d = 1'b1;
            k_valid_d = 1'b0;
         end else if (accept) begin
            m_d       = dec;
            m_valid_d = 1'b1;
         end else begin
            m_valid_d = 1'b0;
         end
      end else if (accept) begin
         k_d       = dec;
         k_valid_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         k_valid_q <= 1'b0;
         // NOTE: the data registers are reset as well because the outputs must read
         // zero during reset, not just be qualified by out_valid.
         m_q       <= '0;
         k_q       <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         k_valid_q <= k_valid_d;
         m_q       <= m_d;
         k_q       <= k_d;
      end
   end

   assign out_valid    = m_valid_q;
   assign out_pc       = m_q.pc;
   assign out_opcode   = m_q.instr[6:0];
   assign out_rd       = m_q.instr[11:7];
   assign out_func3    = m_q.instr[14:12];
   assign out_rs1      = m_q.instr[19:15];
   assign out_rs2      = m_q.instr[24:20];
   assign out_func7    = m_q.instr[31:25];
   assign out_imm      = m_q.imm;
   assign out_fmt      = m_q.fmt;
   assign out_rd_we    = m_q.rd_we;
   assign out_rs1_used = m_q.rs1_used;
   assign out_rs2_used = m_q.rs2_used;
   assign out_illegal  = m_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: one XLEN=32 and one XLEN=64 instance share
// the stimulus; decode vectors come from a table, handshake corners are hand-written.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc32;
   logic [63:0] in_pc64;

   logic        in_ready_32, out_valid_32, rd_we_32, rs1u_32, rs2u_32, ill_32;
   logic [31:0] pc_32, imm_32;
   logic [6:0]  opc_32, f7_32;
   logic [4:0]  rd_32, rs1_32, rs2_32;
   logic [2:0]  f3_32, fmt_32;

   logic        in_ready_64, out_valid_64, rd_we_64, rs1u_64, rs2u_64, ill_64;
   logic [63:0] pc_64, imm_64;
   logic [6:0]  opc_64, f7_64;
   logic [4:0]  rd_64, rs1_64, rs2_64;
   logic [2:0]  f3_64, fmt_64;

   int checks = 0;
   int errors = 0;

   instr_decode_stage #(.XLEN(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_32), .in_instr(in_instr), .in_pc(in_pc32),
      .out_valid(out_valid_32), .out_ready(out_ready), .out_pc(pc_32),
      .out_opcode(opc_32), .out_rd(rd_32), .out_func3(f3_32), .out_rs1(rs1_32),
      .out_rs2(rs2_32), .out_func7(f7_32), .out_imm(imm_32), .out_fmt(fmt_32),
      .out_rd_we(rd_we_32), .out_rs1_used(rs1u_32), .out_rs2_used(rs2u_32),
      .out_illegal(ill_32)
   );

   instr_decode_stage #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_64), .in_instr(in_instr), .in_pc(in_pc64),
      .out_valid(out_valid_64), .out_ready(out_ready), .out_pc(pc_64),
      .out_opcode(opc_64), .out_rd(rd_64), .out_func3(f3_64), .out_rs1(rs1_64),
      .out_rs2(rs2_64), .out_func7(f7_64), .out_imm(imm_64), .out_fmt(fmt_64),
      .out_rd_we(rd_we_64), .out_rs1_used(rs1u_64), .out_rs2_used(rs2u_64),
      .out_illegal(ill_64)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      bit          x64;
      logic [2:0]  fmt;
      logic [63:0] imm;
      logic        rd_we;
      logic        rs1u;
      logic        rs2u;
      logic        ill;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_vec(input vec_t v, input int idx);
      string t;
      logic [31:0] ins;
      ins = v.instr;
      t = $sformatf("v%0d_%s", idx, v.x64 ? "x64" : "x32");
      if (!v.x64) begin
         check({t, "_valid"},  out_valid_32, 1'b1);
         check({t, "_pc"},     pc_32, 32'h1000 + 32'(idx * 4));
         check({t, "_opcode"}, opc_32, ins[6:0]);
         check({t, "_rd"},     rd_32, ins[11:7]);
         check({t, "_f3"},     f3_32, ins[14:12]);
         check({t, "_rs1"},    rs1_32, ins[19:15]);
         check({t, "_rs2"},    rs2_32, ins[24:20]);
         check({t, "_f7"},     f7_32, ins[31:25]);
         check({t, "_fmt"},    fmt_32, v.fmt);
         check({t, "_imm"},    imm_32, v.imm);
         check({t, "_rd_we"},  rd_we_32, v.rd_we);
         check({t, "_rs1u"},   rs1u_32, v.rs1u);
         check({t, "_rs2u"},   rs2u_32, v.rs2u);
         check({t, "_ill"},    ill_32, v.ill);
      end else begin
         check({t, "_valid"},  out_valid_64, 1'b1);
         check({t, "_pc"},     pc_64, 64'h8000_0000_0000_1000 + 64'(idx * 4));
         check({t, "_opcode"}, opc_64, ins[6:0]);
         check({t, "_rd"},     rd_64, ins[11:7]);
         check({t, "_f3"},     f3_64, ins[14:12]);
         check({t, "_rs1"},    rs1_64, ins[19:15]);
         check({t, "_rs2"},    rs2_64, ins[24:20]);
         check({t, "_f7"},     f7_64, ins[31:25]);
         check({t, "_fmt"},    fmt_64, v.fmt);
         check({t, "_imm"},    imm_64, v.imm);
         check({t, "_rd_we"},  rd_we_64, v.rd_we);
         check({t, "_rs1u"},   rs1u_64, v.rs1u);
         check({t, "_rs2u"},   rs2u_64, v.rs2u);
         check({t, "_ill"},    ill_64, v.ill);
      end
   endtask

   task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc32  = pc;
      in_pc64  = {32'h0, pc};
   endtask

   initial begin
      //            instr          x64   fmt   imm                      we    rs1u  rs2u  ill
      vecs[0]  = '{32'hFFF00093, 1'b0, 3'd1, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{32'h00512423, 1'b0, 3'd2, 64'h0000_0000_0000_0008, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{32'hFE000EE3, 1'b0, 3'd3, 64'h0000_0000_FFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{32'h123451B7, 1'b0, 3'd4, 64'h0000_0000_1234_5000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{32'h001000EF, 1'b0, 3'd5, 64'h0000_0000_0000_0800, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{32'h800002B7, 1'b1, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'h0000003B, 1'b0, 3'd7, 64'h0,                   1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{32'h0000003B, 1'b1, 3'd0, 64'h0,                   1'b0, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{32'h00000000, 1'b0, 3'd7, 64'h0,                   1'b0, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{32'h00000000, 1'b1, 3'd7, 64'h0,                   1'b0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{32'h002081B3, 1'b0, 3'd0, 64'h0,                   1'b1, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{32'hFF812503, 1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{32'h0000001B, 1'b1, 3'd1, 64'h0,                   1'b0, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{32'h0000001B, 1'b0, 3'd7, 64'h0,                   1'b0, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{32'h00000090, 1'b0, 3'd7, 64'h0,                   1'b0, 1'b0, 1'b0, 1'b1};
      vecs[15] = '{32'h00000297, 1'b0, 3'd4, 64'h0,                   1'b1, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{32'h0000000F, 1'b0, 3'd1, 64'h0,                   1'b0, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{32'h800002B7, 1'b0, 3'd4, 64'h0000_0000_8000_0000, 1'b1, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc32 = '0; in_pc64 = '0;
      #12;
      check("rst_valid32", out_valid_32, 1'b0);
      check("rst_valid64", out_valid_64, 1'b0);
      check("rst_imm64",   imm_64, 64'h0);
      check("rst_pc32",    pc_32, 32'h0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ready32", in_ready_32, 1'b1);
      check("post_rst_ready64", in_ready_64, 1'b1);
      check("post_rst_valid32", out_valid_32, 1'b0);

      // Decode table: one word per cycle, full throughput with out_ready held high.
      out_ready = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         in_valid = 1'b1;
         in_instr = vecs[i].instr;
         in_pc32  = 32'h1000 + 32'(i * 4);
         in_pc64  = 64'h8000_0000_0000_1000 + 64'(i * 4);
         tick();
         check_vec(vecs[i], i);
      end
      in_valid = 1'b0;
      tick();
      check("drain_valid32", out_valid_32, 1'b0);

      // Backpressure: A held in M, B skids into K, C waits upstream.
      out_ready = 1'b0;
      offer(32'h00100093, 32'h2000);
      tick();
      check("bp_a_valid", out_valid_32, 1'b1);
      check("bp_a_pc",    pc_32, 32'h2000);
      check("bp_a_ready", in_ready_32, 1'b1);
      offer(32'h00200113, 32'h2004);
      tick();
      check("bp_hold1_pc",    pc_32, 32'h2000);
      check("bp_hold1_ready", in_ready_32, 1'b0);
      offer(32'h00300193, 32'h2008);
      tick();
      check("bp_hold2_pc",    pc_32, 32'h2000);
      check("bp_hold2_rd",    rd_32, 5'd1);
      check("bp_hold2_imm",   imm_32, 32'h1);
      check("bp_hold2_ready", in_ready_32, 1'b0);
      out_ready = 1'b1;
      tick();
      check("bp_b_pc",    pc_32, 32'h2004);
      check("bp_b_rd",    rd_32, 5'd2);
      check("bp_b_ready", in_ready_32, 1'b1);
      tick();
      in_valid = 1'b0;
      check("bp_c_valid", out_valid_32, 1'b1);
      check("bp_c_pc",    pc_32, 32'h2008);
      check("bp_c_imm",   imm_32, 32'h3);
      tick();
      check("bp_empty", out_valid_32, 1'b0);

      // Flush with both M and K full, then again with in_ready high: both offers drop.
      out_ready = 1'b0;
      offer(32'h00400213, 32'h3000);
      tick();
      offer(32'h00500293, 32'h3004);
      tick();
      check("fl_full_ready", in_ready_32, 1'b0);
      flush = 1'b1;
      offer(32'h00600313, 32'h3008);
      tick();
      check("fl_valid32", out_valid_32, 1'b0);
      check("fl_valid64", out_valid_64, 1'b0);
      check("fl_ready32", in_ready_32, 1'b1);
      offer(32'h00700393, 32'h300C);
      tick();
      check("fl2_valid", out_valid_32, 1'b0);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("fl_nothing_left", out_valid_32, 1'b0);
      offer(32'h00800413, 32'h3010);
      tick();
      in_valid = 1'b0;
      check("fl_after_valid", out_valid_32, 1'b1);
      check("fl_after_pc",    pc_32, 32'h3010);
      tick();
      check("fl_after_empty", out_valid_32, 1'b0);

      // Asynchronous reset mid-stream, asserted between clock edges.
      out_ready = 1'b0;
      offer(32'hFFF00093, 32'h4000);
      tick();
      offer(32'h123451B7, 32'h4004);
      tick();
      in_valid = 1'b0;
      check("ar_pre_valid", out_valid_32, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid32", out_valid_32, 1'b0);
      check("ar_valid64", out_valid_64, 1'b0);
      check("ar_ready32", in_ready_32, 1'b1);
      check("ar_pc32",    pc_32, 32'h0);
      check("ar_imm32",   imm_32, 32'h0);
      check("ar_imm64",   imm_64, 64'h0);
      check("ar_opcode",  opc_32, 7'h0);
      check("ar_rd",      rd_32, 5'h0);
      check("ar_fmt",     fmt_32, 3'd0);
      check("ar_rd_we",   rd_we_32, 1'b0);
      check("ar_rs1u",    rs1u_32, 1'b0);
      #3;
      rst_n = 1'b1;
      tick();
      check("ar_rel_valid", out_valid_32, 1'b0);
      check("ar_rel_ready", in_ready_32, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
